// File: rtl/fd_gen_pkg.sv
// Shared encodings for the fd_stream_gen frame-data generator:
// lane-fill modes, FSM states and the throttle gap counter width.
package fd_gen_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    localparam int GAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/fd_lane_pattern.sv
// Combinational lane-fill for fd_stream_gen: expands one PW-bit sequence
// value into DW/PW lanes according to the selected fill mode.
module fd_lane_pattern
    import fd_gen_pkg::*;
#(
    parameter int DW = 512,
    parameter int PW = 16
) (
    input  logic [PW-1:0] i_seq,
    input  logic [PW-1:0] i_seed,
    input  logic [1:0]    i_mode,
    output logic [DW-1:0] o_data
);

    // Build every lane from seq/seed; RAMP wraps naturally at PW bits.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < DW / PW; i++) begin
            case (i_mode)
                MODE_INC:   o_data[i*PW +: PW] = i_seq;
                MODE_RAMP:  o_data[i*PW +: PW] = i_seq + PW'(i);
                MODE_CONST: o_data[i*PW +: PW] = i_seed;
                default:    o_data[i*PW +: PW] = (i % 2 == 0) ? i_seq : ~i_seq;
            endcase
        end
    end

endmodule

// File: rtl/fd_stream_gen.sv
// AXI4-Stream frame-data generator. Each accepted start sends cfg_frame_count
// frames of cfg_frame_len beats with tlast framing.
// Optional feature macro: FD_GEN_THROTTLE_EN builds the GAP state and the
// inter-beat gap down-counter; without it cfg_gap is ignored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; outputs quiet
// ST_SEND | tvalid high, beat presented and held until handshake
// ST_GAP  | tvalid low for the latched gap count after a handshake
module fd_stream_gen
    import fd_gen_pkg::*;
#(
    parameter int DW = 512,
    parameter int PW = 16,
    parameter int LW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    cfg_mode,
    input  logic [PW-1:0] cfg_seed,
    input  logic [LW-1:0] cfg_frame_len,
    input  logic [CW-1:0] cfg_frame_count,
    input  logic [7:0]    cfg_gap,
    output logic [DW-1:0] axis_tdata,
    output logic          axis_tvalid,
    output logic          axis_tlast,
    input  logic          axis_tready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] frames_sent
);

    state_t        r_state;
    logic [PW-1:0] r_seq;
    logic [PW-1:0] r_seed;
    logic [1:0]    r_mode;
    logic [LW-1:0] r_len;
    logic [CW-1:0] r_count;
    logic [LW-1:0] r_beat;
    logic [CW-1:0] r_frames;
    logic [DW-1:0] r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_done;

`ifdef FD_GEN_THROTTLE_EN
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
`else
    logic w_unused_gap;
    assign w_unused_gap = ^cfg_gap;
`endif

    logic          w_hs;
    logic [PW-1:0] w_seq_nxt;
    logic [LW-1:0] w_beat_nxt;
    logic          w_last_beat;
    logic          w_idle;
    logic [PW-1:0] w_pat_seq;
    logic [PW-1:0] w_pat_seed;
    logic [1:0]    w_pat_mode;
    logic [DW-1:0] w_pat;

    assign w_hs        = r_tvalid & axis_tready;
    assign w_seq_nxt   = r_seq + PW'(1);
    assign w_beat_nxt  = r_tlast ? '0 : r_beat + LW'(1);
    assign w_last_beat = r_tlast && (r_frames == r_count - CW'(1));
    assign w_idle      = (r_state == ST_IDLE);

    // In IDLE the pattern is computed for the first beat straight from cfg;
    // during a run it is precomputed for the beat after the current one.
    assign w_pat_seq  = w_idle ? cfg_seed : w_seq_nxt;
    assign w_pat_seed = w_idle ? cfg_seed : r_seed;
    assign w_pat_mode = w_idle ? cfg_mode : r_mode;

    fd_lane_pattern #(
        .DW (DW),
        .PW (PW)
    ) u_lane_pattern (
        .i_seq  (w_pat_seq),
        .i_seed (w_pat_seed),
        .i_mode (w_pat_mode),
        .o_data (w_pat)
    );

    // Run-control FSM with registered AXIS outputs, counters and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_seq     <= '0;
            r_seed    <= '0;
            r_mode    <= MODE_INC;
            r_len     <= '0;
            r_count   <= '0;
            r_beat    <= '0;
            r_frames  <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_done    <= 1'b0;
`ifdef FD_GEN_THROTTLE_EN
            r_gap     <= '0;
            r_gap_cnt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_frames <= '0;
                        if (cfg_frame_len == '0 || cfg_frame_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= ST_SEND;
                            r_seed   <= cfg_seed;
                            r_mode   <= cfg_mode;
                            r_len    <= cfg_frame_len;
                            r_count  <= cfg_frame_count;
                            r_seq    <= cfg_seed;
                            r_beat   <= '0;
                            r_tdata  <= w_pat;
                            r_tvalid <= 1'b1;
                            r_tlast  <= (cfg_frame_len == LW'(1));
`ifdef FD_GEN_THROTTLE_EN
                            r_gap    <= cfg_gap;
`endif
                        end
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_seq   <= w_seq_nxt;
                        r_tdata <= w_pat;
                        if (r_tlast) begin
                            r_frames <= r_frames + CW'(1);
                        end
                        if (w_last_beat || abort) begin
                            r_state  <= ST_IDLE;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_beat  <= w_beat_nxt;
                            r_tlast <= (w_beat_nxt == r_len - LW'(1));
`ifdef FD_GEN_THROTTLE_EN
                            if (r_gap != '0) begin
                                r_state   <= ST_GAP;
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= r_gap;
                            end
`endif
                        end
                    end
                end
`ifdef FD_GEN_THROTTLE_EN
                ST_GAP: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_tlast <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_gap_cnt == GAP_W'(1)) begin
                        r_state  <= ST_SEND;
                        r_tvalid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
`endif
                default: begin
                    r_state  <= ST_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign axis_tdata  = r_tdata;
    assign axis_tvalid = r_tvalid;
    assign axis_tlast  = r_tlast;
    assign busy        = !w_idle;
    assign done        = r_done;
    assign frames_sent = r_frames;

endmodule

// File: doc/fd_stream_gen.md
# fd_stream_gen

Parametrised AXI4-Stream frame-data generator: the successor to the team's fixed 512-bit incrementing-word source. Each `start` sends a programmable number of frames of programmable length with `tlast` framing. Four lane-fill patterns and optional inter-beat throttling are available. It sits upstream of the LDP manager as a test and bring-up traffic source, and drives a standard AXIS master port.

## Interface
- `DW`, 512, stream data width; must be a multiple of `PW`.
- `PW`, 16, pattern word width; lanes = `DW/PW`.
- `LW`, 16, width of the frame-length field.
- `CW`, 16, width of the frame-count field.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `abort`  in  1  level; ends the run at the next beat boundary.
- `cfg_mode`  in  2  fill pattern: 0 INC, 1 RAMP, 2 CONST, 3 ALT.
- `cfg_seed`  in  PW  initial sequence value.
- `cfg_frame_len`  in  LW  beats per frame.
- `cfg_frame_count`  in  CW  frames per run.
- `cfg_gap`  in  8  idle cycles inserted after each accepted beat.
- `axis_tdata`  out  DW  beat data.
- `axis_tvalid`  out  1  AXIS valid.
- `axis_tlast`  out  1  high on the final beat of each frame.
- `axis_tready`  in  1  AXIS ready.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `frames_sent`  out  CW  frames completed in the current or last run.

## Operation
- All `cfg_*` inputs are latched on the accepted `start`; later changes do not affect a run in progress.
- Zero-length run: `cfg_frame_len==0` or `cfg_frame_count==0` at `start` sends no beats. `done` pulses the following cycle, `frames_sent`=0, and the block returns to IDLE.
- Sequence `seq` (PW bits):
  - loads `cfg_seed` at `start`;
  - increments by 1 on every handshake (`tvalid & tready`), modulo 2^PW;
  - is not reset between frames.
- Lane i (bits `[i*PW +: PW]`):
  - INC: `seq`.
  - RAMP: `seq + i`, mod 2^PW.
  - CONST: `cfg_seed` on every beat.
  - ALT: `seq` for even i, `~seq` for odd i.
- State machine:
  - IDLE -> SEND on `start`.
  - SEND: `tvalid`=1. On handshake:
    - final beat of final frame, or `abort` high -> IDLE, and `done` pulses;
    - otherwise, if latched gap > 0 -> GAP;
    - otherwise stay in SEND.
  - GAP: `tvalid`=0 for exactly `gap` cycles, then return to SEND. `abort` in GAP -> IDLE immediately, and `done` pulses.
- `tlast`=1 when beat counter == `frame_len-1`. The beat counter clears after a `tlast` handshake. `frames_sent` increments on each `tlast` handshake.
- `abort` never forces `tlast`; an aborted frame is not counted.
- `start` while busy is ignored.
- AXIS rule: once `tvalid` is high, `tvalid`, `tdata` and `tlast` hold stable until handshake.

## Timing
- Reset values:
  - `tvalid`, `tlast`, `busy`, `done` = 0;
  - `tdata` = 0;
  - `frames_sent` = 0;
  - state = IDLE.
- `start` in cycle N -> `tvalid`=1 in cycle N+1, lane data from `seq=cfg_seed`.
- With gap=0 and `tready` held 1: one beat per cycle, no bubbles, including across frame boundaries.
- With gap=g: one beat per g+1 cycles at best.
- `done` is registered: it is high the cycle after the final handshake, coincident with `busy`=0 and `tvalid`=0.
- `frames_sent` updates in the cycle after the `tlast` handshake, and holds until the next accepted `start`, which clears it.
- Reset asserted mid-frame: every output returns to its reset value asynchronously. No partial frame resumes after reset.

## Configuration
- `FD_GEN_THROTTLE_EN` defined:
  - the GAP state and 8-bit gap counter exist;
  - `cfg_gap` behaves as described above.
- `FD_GEN_THROTTLE_EN` undefined:
  - GAP state and counter are not built;
  - `cfg_gap` is ignored (port retained);
  - beats are always back-to-back, subject only to `tready`.

## Structure
- Package `fd_gen_pkg` holds:
  - mode encodings `MODE_INC/RAMP/CONST/ALT`;
  - state encodings `ST_IDLE/ST_SEND/ST_GAP`;
  - gap width constant 8.
- Sub-module `fd_lane_pattern` (purely combinational; parameters DW, PW): maps `seq`, `seed` and `mode` to `tdata`. It is instantiated once.
- Counters, FSM and AXIS registers live in the top level.

## Test plan
- INC, seed=0x0000, len=4, count=2, gap=0, `tready`=1 -> 8 consecutive beats with all lanes = 0..7; `tlast` on beats 3 and 7; `done` one cycle after beat 7; `frames_sent`=2.
- RAMP, seed=0xFFFE, len=3, count=1 -> beat 0: lane0=0xFFFE, lane1=0xFFFF, lane2=0x0000; beat 1: lane0=0xFFFF (wrap verified).
- Throttle (`FD_GEN_THROTTLE_EN`), gap=2, len=3, count=1, `tready`=1 -> `tvalid` pattern 1,0,0,1,0,0,1; then `done`. Without the macro: 1,1,1.
- Backpressure: `tready` toggles 1,0,0,1 per cycle -> `tdata`/`tlast` stable while stalled; beat sequence unbroken; total beats = len×count.
- `abort` raised during the stalled beat 1 of frame 0 (len=5) -> beat 1 completes on handshake with no `tlast`; then IDLE; `done` pulses; `frames_sent`=0.
- `cfg_frame_count`=0 -> no `tvalid`; `done` the next cycle. `reset` pulsed mid-run -> `tvalid`=0 and `busy`=0 immediately, and a subsequent `start` restarts from seed.
